// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - shared types and constants for the serial codec interface
package codec_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int CNT_W     = 10;
    localparam int SCLK_BIT  = 4;
    localparam int LRCLK_BIT = 9;
    localparam int MCLK_BIT  = 1;

    localparam logic [4:0] SMPL_EDGE = 5'd15;
    localparam logic [4:0] SHFT_EDGE = 5'd31;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/codec_clkgen.sv
// rtl/codec_clkgen.sv - frame counter, codec clocks and bit/frame edge strobes
module codec_clkgen
    import codec_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_mclk,
    output logic             o_sclk,
    output logic             o_lrclk,
    output logic             o_smpl_en,
    output logic             o_shft_en,
    output logic             o_frame_end
);

    logic [CNT_W-1:0] r_cnt;

    // Free-running frame counter; every codec clock is a bit of it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Clocks come straight from register bits so they cannot glitch
    assign o_cnt       = r_cnt;
    assign o_mclk      = r_cnt[MCLK_BIT];
    assign o_sclk      = r_cnt[SCLK_BIT];
    assign o_lrclk     = r_cnt[LRCLK_BIT];

    // Strobes mark the clk edge on which SCLK rises, SCLK falls, and the frame wraps
    assign o_smpl_en   = (r_cnt[4:0] == SMPL_EDGE);
    assign o_shft_en   = (r_cnt[4:0] == SHFT_EDGE);
    assign o_frame_end = (r_cnt == CNT_MAX);

endmodule

// File: rtl/codec_intf.sv
// rtl/codec_intf.sv - left-justified 16-bit codec serializer/deserializer with valid strobes
module codec_intf
    import codec_pkg::*;
#(
    parameter int SMPL_W    = 16,
    parameter int VALID_LEN = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [SMPL_W-1:0] lft_out,
    input  logic signed [SMPL_W-1:0] rht_out,
    input  logic                     SDin,
    output logic signed [SMPL_W-1:0] lft_in,
    output logic signed [SMPL_W-1:0] rht_in,
    output logic                     valid,
    output logic                     valid_rise,
    output logic                     valid_fall,
    output logic                     SDout,
    output logic                     MCLK,
    output logic                     SCLK,
    output logic                     LRCLK,
    output logic                     codec_rst_n
);

    localparam int               FRM_W = 2 * SMPL_W;
    localparam logic [CNT_W-1:0] VLEN  = CNT_W'(VALID_LEN);

    logic [CNT_W-1:0]         w_cnt;
    logic                     w_smpl_en;
    logic                     w_shft_en;
    logic                     w_frame_end;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_codec_on;
    logic                     w_run;

    logic [FRM_W-1:0]         r_in_shft;
    logic [FRM_W-1:0]         r_out_shft;
    logic signed [SMPL_W-1:0] r_lft_in;
    logic signed [SMPL_W-1:0] r_rht_in;
    logic                     r_captured;

    codec_clkgen u_clkgen (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_cnt       (w_cnt),
        .o_mclk      (MCLK),
        .o_sclk      (SCLK),
        .o_lrclk     (LRCLK),
        .o_smpl_en   (w_smpl_en),
        .o_shft_en   (w_shft_en),
        .o_frame_end (w_frame_end)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Advance one step per frame wrap: codec held in reset, then one throwaway frame, then run
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HOLD:    if (w_frame_end) w_state_nxt = PRIME;
            PRIME:   if (w_frame_end) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = HOLD;
        endcase
    end

    // Codec leaves reset once we are past HOLD; data is only trusted in RUN
    always_comb begin
        w_codec_on = (r_state != HOLD);
        w_run      = (r_state == RUN);
    end

    // ADC deserializer: one bit per SCLK rising edge, MSB of left channel first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_shft <= '0;
        end else if (w_smpl_en) begin
            r_in_shft <= {r_in_shft[FRM_W-2:0], SDin};
        end
    end

    // Frame-end capture of ADC samples; held stable for the whole following frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft_in   <= '0;
            r_rht_in   <= '0;
            r_captured <= 1'b0;
        end else if (w_frame_end) begin
            r_captured <= w_run;
            if (w_run) begin
                r_lft_in <= r_in_shft[FRM_W-1:SMPL_W];
                r_rht_in <= r_in_shft[SMPL_W-1:0];
            end
        end
    end

    // DAC serializer: load at frame wrap beats the shift, shift on SCLK falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_shft <= '0;
        end else if (w_frame_end) begin
            r_out_shft <= w_run ? {lft_out, rht_out} : '0;
        end else if (w_shft_en) begin
            r_out_shft <= {r_out_shft[FRM_W-2:0], 1'b0};
        end
    end

    assign lft_in      = r_lft_in;
    assign rht_in      = r_rht_in;
    assign SDout       = r_out_shft[FRM_W-1];
    assign codec_rst_n = w_codec_on;

    // Valid window opens at the start of each frame that follows a RUN capture
    assign valid       = r_captured & (w_cnt < VLEN);
    assign valid_rise  = r_captured & (w_cnt == '0);
    assign valid_fall  = r_captured & (w_cnt == VLEN);

endmodule

// File: tb/tb_codec_intf.sv
// tb/tb_codec_intf.sv - directed frame-level bench for codec_intf
module tb_codec_intf;

    localparam int VLEN = 32;

    logic        clk;
    logic        rst_n;
    logic [15:0] lft_out;
    logic [15:0] rht_out;
    logic        SDin;

    logic [15:0] lft_in, rht_in;
    logic        valid, valid_rise, valid_fall, SDout, MCLK, SCLK, LRCLK, codec_rst_n;

    logic [15:0] lft_in1, rht_in1;
    logic        valid1, valid_rise1, valid_fall1, SDout1, MCLK1, SCLK1, LRCLK1, codec_rst_n1;

    int n_vec;
    int n_err;

    logic prev_mclk, prev_sclk, prev_lrclk;

    codec_intf #(.SMPL_W(16), .VALID_LEN(VLEN)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lft_out     (lft_out),
        .rht_out     (rht_out),
        .SDin        (SDin),
        .lft_in      (lft_in),
        .rht_in      (rht_in),
        .valid       (valid),
        .valid_rise  (valid_rise),
        .valid_fall  (valid_fall),
        .SDout       (SDout),
        .MCLK        (MCLK),
        .SCLK        (SCLK),
        .LRCLK       (LRCLK),
        .codec_rst_n (codec_rst_n)
    );

    codec_intf #(.SMPL_W(16), .VALID_LEN(1)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .lft_out     (lft_out),
        .rht_out     (rht_out),
        .SDin        (SDin),
        .lft_in      (lft_in1),
        .rht_in      (rht_in1),
        .valid       (valid1),
        .valid_rise  (valid_rise1),
        .valid_fall  (valid_fall1),
        .SDout       (SDout1),
        .MCLK        (MCLK1),
        .SCLK        (SCLK1),
        .LRCLK       (LRCLK1),
        .codec_rst_n (codec_rst_n1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full frame starting at cnt=0: codec model drives SDin from adc, EQ presents outw only
    // just before the wrap edge, and the frame's outputs are checked against the expectations
    task automatic run_frame(input logic [31:0] adc, input logic [31:0] outw,
                             input logic [31:0] exp_lr, input logic [31:0] exp_sd,
                             input bit exp_cap, input bit exp_crst);
        int vcnt, rcnt, rpos, fpos;
        int v1cnt, r1pos, f1pos;
        int mrise, srise, lrhi, lrbad, sd_unstable;
        logic [31:0] sdw;
        logic sd0;
        vcnt = 0; rcnt = 0; rpos = -1; fpos = -1;
        v1cnt = 0; r1pos = -1; f1pos = -1;
        mrise = 0; srise = 0; lrhi = 0; lrbad = 0; sd_unstable = 0;
        sdw = '0; sd0 = 1'b0;
        for (int c = 0; c < 1024; c++) begin
            SDin = adc[31 - (c >> 5)];
            if (c == 1023) begin
                lft_out = outw[31:16];
                rht_out = outw[15:0];
            end else begin
                lft_out = 16'($urandom);
                rht_out = 16'($urandom);
            end
            if (c == 0 || c == 1023) begin
                chk(c == 0 ? "lft_in_start" : "lft_in_end", {16'h0, lft_in}, {16'h0, exp_lr[31:16]});
                chk(c == 0 ? "rht_in_start" : "rht_in_end", {16'h0, rht_in}, {16'h0, exp_lr[15:0]});
                chk(c == 0 ? "codec_rst_start" : "codec_rst_end", 32'(codec_rst_n), 32'(exp_crst));
            end
            if (valid) vcnt++;
            if (valid_rise) begin rcnt++; rpos = c; end
            if (valid_fall) fpos = c;
            if (valid1) v1cnt++;
            if (valid_rise1) r1pos = c;
            if (valid_fall1) f1pos = c;
            if ((c % 32) == 0) sd0 = SDout;
            else if (SDout !== sd0) sd_unstable++;
            if ((c % 32) == 16) sdw = {sdw[30:0], SDout};
            if (!prev_mclk && MCLK) mrise++;
            if (!prev_sclk && SCLK) srise++;
            if (LRCLK) lrhi++;
            if ((LRCLK !== prev_lrclk) && !(prev_sclk && !SCLK)) lrbad++;
            prev_mclk  = MCLK;
            prev_sclk  = SCLK;
            prev_lrclk = LRCLK;
            tick();
        end
        chk("valid_len",      32'(vcnt),  exp_cap ? 32'(VLEN) : 32'd0);
        chk("rise_count",     32'(rcnt),  exp_cap ? 32'd1 : 32'd0);
        chk("rise_pos",       32'(rpos),  exp_cap ? 32'd0 : 32'hFFFF_FFFF);
        chk("fall_pos",       32'(fpos),  exp_cap ? 32'(VLEN) : 32'hFFFF_FFFF);
        chk("vlen1_valid",    32'(v1cnt), exp_cap ? 32'd1 : 32'd0);
        chk("vlen1_rise_pos", 32'(r1pos), exp_cap ? 32'd0 : 32'hFFFF_FFFF);
        chk("vlen1_fall_pos", 32'(f1pos), exp_cap ? 32'd1 : 32'hFFFF_FFFF);
        chk("sdout_word",     sdw,        exp_sd);
        chk("sdout_hold",     32'(sd_unstable), 32'd0);
        chk("mclk_rises",     32'(mrise), 32'd256);
        chk("sclk_rises",     32'(srise), 32'd32);
        chk("lrclk_high",     32'(lrhi),  32'd512);
        chk("lrclk_on_sclk_fall", 32'(lrbad), 32'd0);
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_lft_in"},      {16'h0, lft_in}, 32'd0);
        chk({pfx, "_rht_in"},      {16'h0, rht_in}, 32'd0);
        chk({pfx, "_valid"},       32'(valid),       32'd0);
        chk({pfx, "_valid_rise"},  32'(valid_rise),  32'd0);
        chk({pfx, "_valid_fall"},  32'(valid_fall),  32'd0);
        chk({pfx, "_sdout"},       32'(SDout),       32'd0);
        chk({pfx, "_mclk"},        32'(MCLK),        32'd0);
        chk({pfx, "_sclk"},        32'(SCLK),        32'd0);
        chk({pfx, "_lrclk"},       32'(LRCLK),       32'd0);
        chk({pfx, "_codec_rst_n"}, 32'(codec_rst_n), 32'd0);
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        prev_mclk  = 1'b0;
        prev_sclk  = 1'b0;
        prev_lrclk = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        SDin    = 1'b0;
        lft_out = '0;
        rht_out = '0;
        prev_mclk  = 1'b0;
        prev_sclk  = 1'b0;
        prev_lrclk = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        release_reset();

        // HOLD, PRIME, first RUN frame, then two captured frames
        run_frame($urandom, 32'h5555_AAAA, 32'h0, 32'h0, 1'b0, 1'b0);
        run_frame($urandom, 32'h33CC_33CC, 32'h0, 32'h0, 1'b0, 1'b1);
        run_frame(32'h1234_ABCD, 32'h8001_7FFE, 32'h0, 32'h0, 1'b0, 1'b1);
        run_frame(32'h7FFF_8000, 32'h7FFF_8000, 32'h1234_ABCD, 32'h8001_7FFE, 1'b1, 1'b1);
        run_frame(32'hFFFF_0001, 32'h0F0F_F0F0, 32'h7FFF_8000, 32'h7FFF_8000, 1'b1, 1'b1);

        // Walk to cnt=500 of the next RUN frame, then hit reset asynchronously
        for (int c = 0; c < 500; c++) begin
            SDin    = 1'b1;
            lft_out = 16'($urandom);
            rht_out = 16'($urandom);
            tick();
        end
        chk("pre_rst_lft_in",   {16'h0, lft_in}, 32'h0000_FFFF);
        chk("pre_rst_sdout",    32'(SDout),       32'd1);
        chk("pre_rst_sclk",     32'(SCLK),        32'd1);
        chk("pre_rst_codec_rst",32'(codec_rst_n), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        release_reset();

        // Full start-up sequence repeats after the mid-frame reset
        run_frame($urandom, $urandom, 32'h0, 32'h0, 1'b0, 1'b0);
        run_frame($urandom, $urandom, 32'h0, 32'h0, 1'b0, 1'b1);
        run_frame(32'h0F0F_5A5A, 32'hC001_0003, 32'h0, 32'h0, 1'b0, 1'b1);
        run_frame(32'h0, 32'h0, 32'h0F0F_5A5A, 32'hC001_0003, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
